rf_multiport: RTL and testbench

- Parametrised successor to the single-cycle datapath's 32x32 register file.
- Provides N combinational read ports, one synchronous write port, and a hardwired-zero register 0.
- Adds a per-register pending-write scoreboard so the control unit can detect RAW hazards.
- Sits between the decode stage (read addresses, reservations) and the writeback mux (write data).

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_multiport_if.sv | 43 ++++
 rtl/rf_scoreboard.sv | 96 +++++++++
 rtl/rf_multiport.sv | 94 +++++++++
 tb/tb_rf_multiport.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multiport register file and its scoreboard.
//   RF_DW       default data width
//   RF_DEPTH    default number of architectural registers
//   rf_addr_t   register address type for the default 32-entry file
//   RF_ZERO_REG address of the hardwired-zero register
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_DEPTH = 32;

    typedef logic [4:0] rf_addr_t;

    localparam rf_addr_t RF_ZERO_REG = 5'd0;

endpackage : rf_pkg

// File: rtl/rf_multiport_if.sv
// ----------------------------------------------------------------------------
// rf_multiport_if
// Bundle of the register-file read, write, reservation and debug signals.
//   RFRA   read addresses, port k at [k*AW +: AW]
//   RFRD   read data,      port k at [k*DW +: DW]
//   RFRDY  per-port "no pending write" flags
//   RFWE/RFWA/RFWD  write port
//   RSVE/RSVA       reservation (pending-write) port
//   PEND   number of pending registers
//   DBGA/DBGD       debug read port
// Modports: master = decode/writeback side, slave = register file.
// ----------------------------------------------------------------------------
interface rf_multiport_if
    import rf_pkg::*;
#(
    parameter int unsigned DW  = RF_DW,
    parameter int unsigned AW  = $clog2(RF_DEPTH),
    parameter int unsigned NRD = 2
);

    logic [NRD*AW-1:0] RFRA;
    logic [NRD*DW-1:0] RFRD;
    logic [NRD-1:0]    RFRDY;
    logic              RFWE;
    logic [AW-1:0]     RFWA;
    logic [DW-1:0]     RFWD;
    logic              RSVE;
    logic [AW-1:0]     RSVA;
    logic [AW:0]       PEND;
    logic [AW-1:0]     DBGA;
    logic [DW-1:0]     DBGD;

    modport master (
        output RFRA, RFWE, RFWA, RFWD, RSVE, RSVA, DBGA,
        input  RFRD, RFRDY, PEND, DBGD
    );

    modport slave (
        input  RFRA, RFWE, RFWA, RFWD, RSVE, RSVA, DBGA,
        output RFRD, RFRDY, PEND, DBGD
    );

endinterface : rf_multiport_if

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write scoreboard: one busy bit per register (register 0 never busy),
// an incrementally maintained pending count, and per-read-port ready flags.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_rsve, i_rsva      reserve: mark register as awaiting a producer
//   i_rfwe, i_rfwa      write: producer result retires, busy cleared
//   i_rfra              packed read addresses, port k at [k*AW +: AW]
//   o_rfrdy             bit k = read port k sees no pending write
//   o_pend              registered count of busy registers
// Optional feature macro: RF_WRITE_BYPASS_EN (ready asserted for a register
// being written in the current cycle unless it is re-reserved the same cycle).
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int unsigned DEPTH = RF_DEPTH,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rsve,
    input  logic [AW-1:0]     i_rsva,
    input  logic              i_rfwe,
    input  logic [AW-1:0]     i_rfwa,
    input  logic [NRD*AW-1:0] i_rfra,
    output logic [NRD-1:0]    o_rfrdy,
    output logic [AW:0]       o_pend
);

    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_pend;

    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_pend_nxt;
    logic             w_rsv_hit;
    logic             w_set;
    logic             w_clr;
    logic [NRD-1:0]   w_rdy;

    // Next busy vector and count; a same-cycle reserve overrides the clear.
    always_comb begin
        w_rsv_hit  = i_rsve && (i_rsva != AW'(RF_ZERO_REG));
        w_set      = w_rsv_hit && !r_busy[i_rsva];
        w_clr      = i_rfwe && r_busy[i_rfwa] && !(w_rsv_hit && (i_rsva == i_rfwa));

        w_busy_nxt = r_busy;
        if (i_rfwe) begin
            w_busy_nxt[i_rfwa] = 1'b0;
        end
        if (w_rsv_hit) begin
            w_busy_nxt[i_rsva] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;

        w_pend_nxt = r_pend;
        if (w_set && !w_clr) begin
            w_pend_nxt = r_pend + (AW+1)'(1);
        end else if (w_clr && !w_set) begin
            w_pend_nxt = r_pend - (AW+1)'(1);
        end
    end

    // Busy bits and pending count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_pend <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    // Per-port ready flags from the registered busy bits.
    always_comb begin : ready_gen
        logic [AW-1:0] v_ra;
        w_rdy = '0;
        v_ra  = '0;
        for (int k = 0; k < NRD; k++) begin
            v_ra     = i_rfra[k*AW +: AW];
            w_rdy[k] = ~r_busy[v_ra];
`ifdef RF_WRITE_BYPASS_EN
            // Forwarded value is ready now unless a new producer claims it.
            if (i_rfwe && (i_rfwa != AW'(RF_ZERO_REG)) && (v_ra == i_rfwa)) begin
                w_rdy[k] = !(i_rsve && (i_rsva == i_rfwa));
            end
`endif
        end
    end

    assign o_rfrdy = w_rdy;
    assign o_pend  = r_pend;

endmodule : rf_scoreboard

// File: rtl/rf_multiport.sv
// ----------------------------------------------------------------------------
// rf_multiport
// Parametrised register file: NRD combinational read ports, one synchronous
// write port, hardwired-zero register 0, and a pending-write scoreboard used
// by the control unit for RAW hazard detection.
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset (clears registers and scoreboard)
//   bus   rf_multiport_if.slave: read/write/reserve/debug signals
// Optional feature macro: RF_WRITE_BYPASS_EN. When defined, a read port whose
// address matches the current non-zero write address returns the write data
// in the same cycle; the debug port is never bypassed.
// ----------------------------------------------------------------------------
module rf_multiport
    import rf_pkg::*;
#(
    parameter  int unsigned DW    = RF_DW,
    parameter  int unsigned DEPTH = RF_DEPTH,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    rf_multiport_if.slave bus
);

    logic [DW-1:0]     r_mem [DEPTH];

    logic              w_wr_en;
    logic [NRD*DW-1:0] w_rfrd;
    logic [DW-1:0]     w_dbgd;
    logic [NRD-1:0]    w_rfrdy;
    logic [AW:0]       w_pend;

    assign w_wr_en = bus.RFWE && (bus.RFWA != AW'(RF_ZERO_REG));

    // Register storage; writes to register 0 are dropped so it stays zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.RFWA] <= bus.RFWD;
        end
    end

    // Combinational read ports.
    always_comb begin : read_gen
        logic [AW-1:0] v_ra;
        w_rfrd = '0;
        v_ra   = '0;
        for (int k = 0; k < NRD; k++) begin
            v_ra = bus.RFRA[k*AW +: AW];
            if (v_ra == AW'(RF_ZERO_REG)) begin
                w_rfrd[k*DW +: DW] = '0;
`ifdef RF_WRITE_BYPASS_EN
            end else if (w_wr_en && (v_ra == bus.RFWA)) begin
                w_rfrd[k*DW +: DW] = bus.RFWD;
`endif
            end else begin
                w_rfrd[k*DW +: DW] = r_mem[v_ra];
            end
        end
    end

    // Debug port always shows stored state.
    always_comb begin
        w_dbgd = '0;
        if (bus.DBGA != AW'(RF_ZERO_REG)) begin
            w_dbgd = r_mem[bus.DBGA];
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_rsve  (bus.RSVE),
        .i_rsva  (bus.RSVA),
        .i_rfwe  (bus.RFWE),
        .i_rfwa  (bus.RFWA),
        .i_rfra  (bus.RFRA),
        .o_rfrdy (w_rfrdy),
        .o_pend  (w_pend)
    );

    assign bus.RFRD  = w_rfrd;
    assign bus.DBGD  = w_dbgd;
    assign bus.RFRDY = w_rfrdy;
    assign bus.PEND  = w_pend;

endmodule : rf_multiport

// File: tb/tb_rf_multiport.sv
// ----------------------------------------------------------------------------
// tb_rf_multiport
// Directed scenarios plus randomized traffic against an array-based model of
// the register file and its pending-write scoreboard.
// ----------------------------------------------------------------------------
module tb_rf_multiport;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRD   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_multiport_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    rf_multiport #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_busy [DEPTH];

    // Stimulus shadow
    logic [AW-1:0] t_ra [NRD];
    logic          t_we;
    logic [AW-1:0] t_wa;
    logic [DW-1:0] t_wd;
    logic          t_rsve;
    logic [AW-1:0] t_rsva;
    logic [AW-1:0] t_dbga;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit bypass_hit(input logic [AW-1:0] a);
`ifdef RF_WRITE_BYPASS_EN
        return t_we && (t_wa != 0) && (a == t_wa);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int k);
        if (t_ra[k] == 0)          return '0;
        if (bypass_hit(t_ra[k]))   return t_wd;
        return m_reg[t_ra[k]];
    endfunction

    function automatic logic exp_rdy(input int k);
        if (bypass_hit(t_ra[k])) return !(t_rsve && (t_rsva == t_wa));
        return !m_busy[t_ra[k]];
    endfunction

    function automatic int exp_pend();
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_edge();
        if (t_we && t_wa != 0) m_reg[t_wa] = t_wd;
        if (t_we)              m_busy[t_wa] = 1'b0;
        if (t_rsve && t_rsva != 0) m_busy[t_rsva] = 1'b1;
    endtask

    task automatic apply();
        bus.RFWE = t_we;
        bus.RFWA = t_wa;
        bus.RFWD = t_wd;
        bus.RSVE = t_rsve;
        bus.RSVA = t_rsva;
        bus.DBGA = t_dbga;
        for (int k = 0; k < int'(NRD); k++) bus.RFRA[k*AW +: AW] = t_ra[k];
    endtask

    task automatic check_outputs(input string pfx);
        for (int k = 0; k < int'(NRD); k++) begin
            check_val($sformatf("%s_rd%0d", pfx, k), 64'(bus.RFRD[k*DW +: DW]), 64'(exp_rd(k)));
            check_val($sformatf("%s_rdy%0d", pfx, k), 64'(bus.RFRDY[k]), 64'(exp_rdy(k)));
        end
        check_val($sformatf("%s_dbg", pfx), 64'(bus.DBGD),
                  64'((t_dbga == 0) ? '0 : m_reg[t_dbga]));
        check_val($sformatf("%s_pend", pfx), 64'(bus.PEND), 64'(exp_pend()));
    endtask

    // Apply inputs, check pre-edge outputs, advance model and DUT one edge.
    task automatic tick(input string pfx);
        apply();
        #1;
        check_outputs(pfx);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        t_we   = 1'b0;
        t_rsve = 1'b0;
        apply();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < int'(NRD); k++) t_ra[k] = '0;
        t_we = 0; t_wa = 0; t_wd = 0; t_rsve = 0; t_rsva = 0; t_dbga = 0;
        apply();
        model_reset();

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();
        check_outputs("rst");
        check_val("rst_rfrdy", 64'(bus.RFRDY), 64'(2'b11));
        check_val("rst_pend", 64'(bus.PEND), 64'd0);

        // Register 0 stays zero and is never reserved
        t_we = 1; t_wa = 0; t_wd = 32'hDEAD_BEEF;
        tick("z_wr");
        idle();
        check_val("z_rd0", 64'(bus.RFRD[DW-1:0]), 64'd0);
        t_rsve = 1; t_rsva = 0;
        tick("z_rsv");
        idle();
        check_val("z_pend", 64'(bus.PEND), 64'd0);

        // Back-to-back writes to R9
        t_ra[0] = 9; t_ra[1] = 9; t_dbga = 9;
        t_we = 1; t_wa = 9; t_wd = 32'd250;
        tick("r9_a");
        check_val("r9_e1_rd0", 64'(bus.RFRD[DW-1:0]), 64'd250);
        check_val("r9_e1_rd1", 64'(bus.RFRD[2*DW-1:DW]), 64'd250);
        t_wd = 32'd267;
        tick("r9_b");
        idle();
        check_val("r9_e2_rd0", 64'(bus.RFRD[DW-1:0]), 64'd267);
        check_val("r9_e2_rd1", 64'(bus.RFRD[2*DW-1:DW]), 64'd267);
        check_val("r9_e2_dbg", 64'(bus.DBGD), 64'd267);

        // Reserve R3, then retire it with a write
        t_rsve = 1; t_rsva = 3;
        tick("r3_rsv");
        t_ra[0] = 3;
        idle();
        check_val("r3_rdy_busy", 64'(bus.RFRDY[0]), 64'd0);
        check_val("r3_pend1", 64'(bus.PEND), 64'd1);
        t_we = 1; t_wa = 3; t_wd = 32'hFFFF_FFFB;
        tick("r3_wr");
        idle();
        check_val("r3_rdy_free", 64'(bus.RFRDY[0]), 64'd1);
        check_val("r3_rd", 64'(bus.RFRD[DW-1:0]), 64'hFFFF_FFFB);
        check_val("r3_pend0", 64'(bus.PEND), 64'd0);

        // Same-edge reserve and write to busy R7: reserve wins
        t_rsve = 1; t_rsva = 7;
        tick("r7_rsv");
        t_rsve = 1; t_rsva = 7; t_we = 1; t_wa = 7; t_wd = 32'h1234_5678;
        tick("r7_both");
        t_ra[0] = 7;
        idle();
        check_val("r7_rdy", 64'(bus.RFRDY[0]), 64'd0);
        check_val("r7_pend", 64'(bus.PEND), 64'd1);
        check_val("r7_rd", 64'(bus.RFRD[DW-1:0]), 64'h1234_5678);
        t_we = 1; t_wa = 7; t_wd = 32'h0000_0077;
        tick("r7_free");
        idle();
        check_val("r7_pend0", 64'(bus.PEND), 64'd0);

        // Same-cycle visibility of a write to R12
        t_we = 1; t_wa = 12; t_wd = 32'd100;
        tick("r12_old");
        t_ra[1] = 12; t_we = 1; t_wa = 12; t_wd = 32'd192;
        apply();
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check_val("r12_same", 64'(bus.RFRD[2*DW-1:DW]), 64'd192);
`else
        check_val("r12_same", 64'(bus.RFRD[2*DW-1:DW]), 64'd100);
`endif
        tick("r12_wr");
        idle();
        check_val("r12_next", 64'(bus.RFRD[2*DW-1:DW]), 64'd192);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < int'(NRD); k++) t_ra[k] = rand_addr();
            t_we   = 1'($urandom_range(0, 1));
            t_wa   = rand_addr();
            t_wd   = DW'($urandom);
            t_rsve = 1'($urandom_range(0, 1));
            t_rsva = rand_addr();
            t_dbga = rand_addr();
            tick("rnd");
        end

        // Asynchronous reset mid-run
        idle();
        t_we = 1; t_wa = 5; t_wd = 32'd17;
        tick("ar_wr");
        t_ra[0] = 5;
        idle();
        check_val("ar_pre_rd", 64'(bus.RFRD[DW-1:0]), 64'd17);
        t_rsve = 1; t_rsva = 10;
        tick("ar_rsv");
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("ar_rd0", 64'(bus.RFRD[DW-1:0]), 64'd0);
        check_val("ar_pend", 64'(bus.PEND), 64'd0);
        check_val("ar_rfrdy", 64'(bus.RFRDY), 64'(2'b11));
        check_outputs("ar_in");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("ar_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rf_multiport
